// File: rtl/roberts_cross_dsc_core_if.sv
// Pixel window, enable and result bundle for the Roberts-cross DSC core.
// The master drives pixels and enable, and the slave (the core) returns results.
interface roberts_cross_dsc_core_if #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = DATA_WIDTH + 2
);
   logic                  en;
   logic [DATA_WIDTH-1:0] bin_in00;
   logic [DATA_WIDTH-1:0] bin_in01;
   logic [DATA_WIDTH-1:0] bin_in10;
   logic [DATA_WIDTH-1:0] bin_in11;
   logic [DATA_WIDTH-1:0] bin_data_out;
   logic                  op_finished;
   logic [CNT_WIDTH-1:0]  cycle_count;
   logic                  cycle_count_overflow;

   modport master (
      output en, bin_in00, bin_in01, bin_in10, bin_in11,
      input  bin_data_out, op_finished,
      input  cycle_count, cycle_count_overflow
   );

   modport slave (
      input  en, bin_in00, bin_in01, bin_in10, bin_in11,
      output bin_data_out, op_finished,
      output cycle_count, cycle_count_overflow
   );
endinterface

// File: rtl/roberts_cross_dsc_core.sv
// Roberts-cross gradient magnitude using deterministic stochastic computing.
// Thermometer streams are XORed and summed into a saturating accumulator.
module roberts_cross_dsc_core #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_INPUTS = 4,
   parameter int CNT_WIDTH  = DATA_WIDTH + 2,
   parameter int CNT_STRIDE = 1
) (
   input logic gclk,
   input logic rst,
   roberts_cross_dsc_core_if.slave bus
);
   localparam int KW = DATA_WIDTH + 1;
   localparam logic [KW-1:0] K_LAST = {1'b0, {DATA_WIDTH{1'b1}}};
   localparam logic [CNT_WIDTH:0] STRIDE = (CNT_WIDTH+1)'(CNT_STRIDE);

   generate
      if (NUM_INPUTS != 4) begin : g_bad_inputs
         $error("roberts_cross_dsc_core supports NUM_INPUTS == 4 only");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                state;
   state_t                state_nxt;
   logic [KW-1:0]         k;
   logic [DATA_WIDTH-1:0] acc;
   logic [DATA_WIDTH-1:0] acc_nxt;
   logic [DATA_WIDTH:0]   sum;
   logic [CNT_WIDTH-1:0]  cnt;
   logic [CNT_WIDTH:0]    cnt_sum;
   logic                  ovf;
   logic                  step;
   logic                  x00, x01, x10, x11;
   logic                  d0, d1;

   // All four streams share k, so they are maximally correlated.
   assign x00 = bus.bin_in00 > k[DATA_WIDTH-1:0];
   assign x01 = bus.bin_in01 > k[DATA_WIDTH-1:0];
   assign x10 = bus.bin_in10 > k[DATA_WIDTH-1:0];
   assign x11 = bus.bin_in11 > k[DATA_WIDTH-1:0];
   assign d0  = x00 ^ x11;
   assign d1  = x01 ^ x10;

   assign sum     = {1'b0, acc} + {{DATA_WIDTH{1'b0}}, d0}
                  + {{DATA_WIDTH{1'b0}}, d1};
   assign acc_nxt = sum[DATA_WIDTH] ? '1 : sum[DATA_WIDTH-1:0];
   assign cnt_sum = {1'b0, cnt} + STRIDE;

   always_ff @(posedge gclk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (step) state_nxt = (k == K_LAST) ? S_DONE : S_RUN;
   end

   always_comb begin
      step = bus.en && (state != S_DONE);
   end

   always_ff @(posedge gclk or negedge rst) begin
      if (!rst) begin
         k   <= '0;
         acc <= '0;
      end else if (step) begin
         k   <= k + 1'b1;
         acc <= acc_nxt;
      end
   end

   always_ff @(posedge gclk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
         ovf <= 1'b0;
      end else begin
         ovf <= bus.en & cnt_sum[CNT_WIDTH];
         if (bus.en) cnt <= cnt_sum[CNT_WIDTH-1:0];
      end
   end

   assign bus.bin_data_out         = acc;
   assign bus.op_finished          = (state == S_DONE);
   assign bus.cycle_count          = cnt;
   assign bus.cycle_count_overflow = ovf;
endmodule

// File: tb/tb_roberts_cross_dsc_core.sv
// Directed and random bench for roberts_cross_dsc_core.
// Results are checked against a per-position stream model and a closed-form value.
module tb_roberts_cross_dsc_core;
   localparam int DW = 8;
   localparam int CW = DW + 2;
   localparam int NSTEP = 1 << DW;

   logic gclk;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   roberts_cross_dsc_core_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

   roberts_cross_dsc_core #(
      .DATA_WIDTH(DW), .NUM_INPUTS(4), .CNT_WIDTH(CW), .CNT_STRIDE(1)
   ) dut (
      .gclk(gclk),
      .rst (rst),
      .bus (bus)
   );

   initial gclk = 1'b0;
   always #5 gclk = ~gclk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge gclk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge gclk);
      rst    = 1'b0;
      bus.en = 1'b0;
      @(negedge gclk);
      rst = 1'b1;
   endtask

   function automatic int golden(input int a, b, c, d);
      int s;
      s = (a > d ? a - d : d - a) + (b > c ? b - c : c - b);
      return (s > NSTEP - 1) ? NSTEP - 1 : s;
   endfunction

   // a=in00 b=in01 c=in10 d=in11; optional enable stall after stall_at cycles
   task automatic run_op(input string name, input int a, b, c, d,
                         input int stall_at, input int stall_len,
                         input int exp_wall);
      int m, wall, stalled, exp, errs;
      bus.bin_in00 = DW'(a);
      bus.bin_in01 = DW'(b);
      bus.bin_in10 = DW'(c);
      bus.bin_in11 = DW'(d);
      m = 0; wall = 0; stalled = 0; exp = 0; errs = 0;
      while (m < NSTEP && wall < 2 * NSTEP) begin
         if (m == stall_at && stalled < stall_len) begin
            bus.en = 1'b0;
            stalled++;
         end else begin
            bus.en = 1'b1;
         end
         tick();
         wall++;
         if (bus.en) begin
            exp = exp + int'((a > m) != (d > m)) + int'((b > m) != (c > m));
            if (exp > NSTEP - 1) exp = NSTEP - 1;
            m++;
         end
         if (bus.bin_data_out !== DW'(exp)) errs++;
         if (bus.op_finished !== (m == NSTEP)) errs++;
      end
      chk({name, "_trace"}, errs, 0);
      chk({name, "_wall"}, wall, exp_wall);
      chk({name, "_fin"}, bus.op_finished, 1);
      chk({name, "_data"}, bus.bin_data_out, golden(a, b, c, d));
      chk({name, "_cnt"}, bus.cycle_count, NSTEP);
      repeat (5) tick();
      chk({name, "_hold"}, bus.bin_data_out, golden(a, b, c, d));
   endtask

   initial begin
      int pulses, a, b, c, d;
      rst = 1'b0;
      bus.en = 1'b0;
      bus.bin_in00 = '0;
      bus.bin_in01 = '0;
      bus.bin_in10 = '0;
      bus.bin_in11 = '0;
      #12;
      chk("rst_data", bus.bin_data_out, 0);
      chk("rst_fin", bus.op_finished, 0);
      chk("rst_cnt", bus.cycle_count, 0);
      chk("rst_ovf", bus.cycle_count_overflow, 0);

      do_reset();
      run_op("basic", 200, 10, 30, 50, -1, 0, 256);
      do_reset();
      run_op("sat", 255, 0, 255, 0, -1, 0, 256);
      do_reset();
      run_op("zero", 77, 77, 77, 77, -1, 0, 256);
      do_reset();
      run_op("stall", 200, 10, 30, 50, 100, 10, 266);

      do_reset();
      bus.bin_in00 = 8'd200;
      bus.bin_in11 = 8'd50;
      bus.en = 1'b1;
      repeat (100) tick();
      chk("mid_cnt", bus.cycle_count, 100);
      rst = 1'b0;
      #1;
      chk("abort_data", bus.bin_data_out, 0);
      chk("abort_fin", bus.op_finished, 0);
      chk("abort_cnt", bus.cycle_count, 0);
      chk("abort_ovf", bus.cycle_count_overflow, 0);
      @(negedge gclk);
      rst = 1'b1;
      run_op("rerun", 0, 64, 0, 128, -1, 0, 256);

      do_reset();
      bus.bin_in00 = 8'd90;
      bus.bin_in01 = 8'd20;
      bus.bin_in10 = 8'd5;
      bus.bin_in11 = 8'd10;
      bus.en = 1'b1;
      pulses = 0;
      for (int i = 1; i <= 4 * NSTEP; i++) begin
         tick();
         if (bus.cycle_count_overflow === 1'b1) pulses++;
         if (i == NSTEP) chk("wrap_fin256", bus.op_finished, 1);
      end
      chk("wrap_cnt", bus.cycle_count, 0);
      chk("wrap_pulses", pulses, 1);
      chk("wrap_ovf_now", bus.cycle_count_overflow, 1);
      tick();
      chk("wrap_ovf_drop", bus.cycle_count_overflow, 0);
      chk("wrap_cnt1", bus.cycle_count, 1);
      chk("wrap_hold", bus.bin_data_out, golden(90, 20, 5, 10));

      for (int r = 0; r < 4; r++) begin
         a = int'($urandom_range(0, 255));
         b = int'($urandom_range(0, 255));
         c = int'($urandom_range(0, 255));
         d = int'($urandom_range(0, 255));
         do_reset();
         run_op("rand", a, b, c, d, int'($urandom_range(0, 255)),
                3, 259);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
